uarc_bus_responder: RTL



---
 rtl/uarc_bus_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uarc_bus_responder.sv
// uarc_bus_responder: far-end UARC bus endpoint that acks kill/incept/send/stream requests,
// holds the incepted context and queues delivered words in a fall-through FIFO.
module uarc_bus_responder #(
    parameter int WORD_MAG = 5,
    parameter int FIFO_MAG = 2,
    localparam int WORD_WIDTH = 1 << WORD_MAG,
    localparam int DEPTH = 1 << FIFO_MAG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  kill,
    input  logic                  incept,
    input  logic                  send,
    input  logic                  stream,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic [WORD_WIDTH-1:0] self_permission,
    input  logic [WORD_WIDTH-1:0] self_address,
    input  logic [WORD_WIDTH-1:0] incept_permission,
    input  logic [WORD_WIDTH-1:0] incept_address,
    output logic                  kill_ack,
    output logic                  incept_ack,
    output logic                  send_ack,
    output logic                  stream_ack,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_stream,
    input  logic                  out_ready,
    output logic                  running,
    output logic [WORD_WIDTH-1:0] ctx_permission,
    output logic [WORD_WIDTH-1:0] ctx_address,
    output logic [WORD_WIDTH-1:0] ctx_parent,
    output logic [FIFO_MAG:0]     fifo_count,
    output logic [7:0]            drop_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUNNING = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  kill_ack_q, kill_ack_d, incept_ack_q, incept_ack_d;
    logic                  send_ack_q, send_ack_d, stream_ack_q, stream_ack_d;
    logic [WORD_WIDTH-1:0] perm_q, perm_d, addr_q, addr_d, parent_q, parent_d;
    logic [7:0]            drop_q, drop_d;
    logic [FIFO_MAG-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_MAG:0]     count_q, count_d;
    logic [WORD_WIDTH:0]   mem_q [DEPTH];
    logic [WORD_WIDTH:0]   mem_d [DEPTH];
    logic drop, full, pop, room, acc_k, acc_i, acc_s, acc_t, push;

    // A request is blocked only while its own ack is high; ineligible requests do not block lower ones.
    always_comb begin
        drop = (state_q == IDLE) || (self_permission != perm_q);
        full = count_q == (FIFO_MAG+1)'(DEPTH);
        pop = (count_q != '0) && out_ready;
        room = drop || !full || pop;
        acc_k = enable && kill && !kill_ack_q;
        acc_i = enable && incept && !incept_ack_q && state_q == IDLE && !acc_k;
        acc_s = enable && send && !send_ack_q && room && !acc_k && !acc_i;
        acc_t = enable && stream && !stream_ack_q && room && !acc_k && !acc_i && !acc_s;
        push = (acc_s || acc_t) && !drop;
        kill_ack_d = acc_k;
        incept_ack_d = acc_i;
        send_ack_d = acc_s;
        stream_ack_d = acc_t;
        state_d = acc_k ? IDLE : acc_i ? RUNNING : state_q;
        perm_d = acc_i ? incept_permission : perm_q;
        addr_d = acc_i ? incept_address : addr_q;
        parent_d = acc_i ? self_address : parent_q;
        drop_d = ((acc_s || acc_t) && drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
        mem_d = mem_q;
        if (push) mem_d[wr_q] = {data, acc_t};
        wr_d = acc_k ? '0 : wr_q + FIFO_MAG'(push);
        rd_d = acc_k ? '0 : rd_q + FIFO_MAG'(pop);
        count_d = acc_k ? '0 : count_q + (FIFO_MAG+1)'(push) - (FIFO_MAG+1)'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            kill_ack_q <= 1'b0;
            incept_ack_q <= 1'b0;
            send_ack_q <= 1'b0;
            stream_ack_q <= 1'b0;
            perm_q <= '0;
            addr_q <= '0;
            parent_q <= '0;
            drop_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
            mem_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            kill_ack_q <= kill_ack_d;
            incept_ack_q <= incept_ack_d;
            send_ack_q <= send_ack_d;
            stream_ack_q <= stream_ack_d;
            perm_q <= perm_d;
            addr_q <= addr_d;
            parent_q <= parent_d;
            drop_q <= drop_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
            mem_q <= mem_d;
        end
    end

    assign kill_ack = kill_ack_q;
    assign incept_ack = incept_ack_q;
    assign send_ack = send_ack_q;
    assign stream_ack = stream_ack_q;
    assign running = state_q == RUNNING;
    assign ctx_permission = perm_q;
    assign ctx_address = addr_q;
    assign ctx_parent = parent_q;
    assign drop_count = drop_q;
    assign fifo_count = count_q;
    assign out_valid = count_q != '0;
    assign out_data = mem_q[rd_q][WORD_WIDTH:1];
    assign out_stream = mem_q[rd_q][0];
endmodule
